change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200: maximum cycles O_COIN_REQ waits for I_COIN_ACK before faulting (legal range 2..255).
REQ-002 SHALL have port I_CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port I_RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port I_START  input  1  one-cycle request to dispense I_AMOUNT; honoured only in IDLE.
REQ-005 SHALL have port I_AMOUNT  input  16  change to return in cents; sampled only on an honoured I_START.
REQ-006 SHALL have port I_EMPTY  input  6  per-denomination hopper-empty flags; bit i corresponds to coin type i.
REQ-007 SHALL have port I_COIN_ACK  input  1  hopper acknowledges that one coin of O_COIN_TYPE has been ejected.
REQ-008 SHALL have port O_COIN_REQ  output  1  coin eject request to the hopper.
REQ-009 SHALL have port O_COIN_TYPE  output  3  coin type to eject: 0=500, 1=100, 2=25, 3=10, 4=5, 5=1 cents.
REQ-010 SHALL have port O_REMAIN  output  16  change not yet dispensed.
REQ-011 SHALL have port O_COUNT  output  8  coins dispensed in the current transaction.
REQ-012 SHALL have port O_BUSY  output  1  high in every state except IDLE.
REQ-013 SHALL have port O_DONE  output  1  one-cycle pulse when a transaction completes.
REQ-014 SHALL have port O_FAULT  output  1  sticky flag: exact change cannot be completed.

Function
REQ-015 SHALL implement the states IDLE, SELECT, REQ, DONE and FAULT, with all outputs registered.
REQ-016 IDLE: on I_START=1, SHALL load O_REMAIN<=I_AMOUNT and O_COUNT<=0, then go to DONE if I_AMOUNT==0, otherwise to SELECT.
REQ-017 SHALL ignore I_START in every state except IDLE.
REQ-018 SELECT (exactly one cycle): if O_REMAIN==0, SHALL go to DONE.
REQ-019 SELECT: otherwise SHALL choose the lowest type index i whose value is <= O_REMAIN and whose I_EMPTY[i]==0, set O_COIN_TYPE=i and O_COIN_REQ=1, clear the timeout counter, and go to REQ.
REQ-020 SELECT: if no coin type qualifies, SHALL go to FAULT with O_REMAIN unchanged.
REQ-021 SHALL sample I_EMPTY only in SELECT; a change of I_EMPTY during REQ SHALL NOT affect the outstanding request.
REQ-022 REQ: O_COIN_REQ and O_COIN_TYPE SHALL remain stable until an acknowledge or a timeout occurs.
REQ-023 REQ: on I_COIN_ACK=1, SHALL subtract the coin value from O_REMAIN, increment O_COUNT (saturating at 255), drive O_COIN_REQ to 0 on the next cycle, and go to SELECT.
REQ-024 This gives a minimum of one low cycle between consecutive requests.
REQ-025 SHALL ignore I_COIN_ACK whenever O_COIN_REQ is 0.
REQ-026 REQ: the timeout counter SHALL increment each cycle without an acknowledge.
REQ-027 REQ: if no acknowledge has arrived after TIMEOUT cycles, SHALL drop O_COIN_REQ and go to FAULT with O_REMAIN and O_COUNT unchanged.
REQ-028 An acknowledge arriving in the final (TIMEOUT-th) cycle SHALL be honoured in preference to the timeout.
REQ-029 DONE: SHALL assert O_DONE for one cycle and return to IDLE; O_REMAIN and O_COUNT SHALL hold their values until the next honoured I_START.
REQ-030 FAULT: O_FAULT=1, O_BUSY=1 and O_COIN_REQ=0 SHALL hold; the state SHALL exit only via I_RESET.
REQ-031 The subtraction of a coin value from O_REMAIN SHALL never underflow, because a coin is selected only when its value is <= O_REMAIN.
REQ-032 Latency with same-cycle acknowledges: start to first O_COIN_REQ SHALL be 2 cycles, and each additional coin SHALL add 2 cycles.
REQ-033 Latency with same-cycle acknowledges: the final acknowledge to O_DONE SHALL be 2 cycles.

Reset
REQ-034 When I_RESET=1 at a clock edge, SHALL enter IDLE and clear O_COIN_REQ, O_COIN_TYPE, O_REMAIN, O_COUNT, O_BUSY, O_DONE, O_FAULT and the timeout counter.
REQ-035 I_RESET SHALL take priority over all other inputs, including I_START, I_COIN_ACK and a mid-request state; no coin SHALL be counted in the reset cycle.

Verification
REQ-036 I_START with I_AMOUNT=135, I_EMPTY=0, immediate acknowledges -> O_COIN_TYPE sequence 1,2,3; O_COUNT=3; O_REMAIN=0; O_DONE pulse; O_FAULT=0.
REQ-037 I_START with I_AMOUNT=0 -> O_DONE on the cycle after start; no O_COIN_REQ; O_COUNT=0.
REQ-038 I_AMOUNT=30 with I_EMPTY=6'b000100 (quarters empty) -> types 3,3,3; O_COUNT=3; O_DONE.
REQ-039 I_AMOUNT=3 with I_EMPTY=6'b100000 (pennies empty) -> O_FAULT=1, O_REMAIN=3, no O_COIN_REQ; I_START ignored afterwards until I_RESET.
REQ-040 I_AMOUNT=100 with no acknowledge, TIMEOUT=200 -> O_COIN_REQ high for 200 cycles, then O_FAULT=1, O_REMAIN=100, O_COUNT=0.
REQ-041 I_RESET asserted while in REQ with I_COIN_ACK=1 in the same cycle -> next cycle all outputs are 0 and the state is IDLE; a following I_AMOUNT=5 start dispenses type 4 normally.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin change dispenser: issues one hopper eject request at a time, always picking the
// lowest-index coin type that fits, with an acknowledge timeout and a sticky fault.
module change_dispenser #(
    parameter int TIMEOUT = 200
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_START,
    input  logic [15:0] I_AMOUNT,
    input  logic [5:0]  I_EMPTY,
    input  logic        I_COIN_ACK,
    output logic        O_COIN_REQ,
    output logic [2:0]  O_COIN_TYPE,
    output logic [15:0] O_REMAIN,
    output logic [7:0]  O_COUNT,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic        O_FAULT
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        DONE,
        FAULT
    } state_t;

    state_t     state;
    logic [7:0] timer;
    logic       sel_found;
    logic [2:0] sel_type;

    function automatic logic [15:0] coin_value(input logic [2:0] coin);
        case (coin)
            3'd0:    coin_value = 16'd500;
            3'd1:    coin_value = 16'd100;
            3'd2:    coin_value = 16'd25;
            3'd3:    coin_value = 16'd10;
            3'd4:    coin_value = 16'd5;
            default: coin_value = 16'd1;
        endcase
    endfunction

    // Scan from the smallest coin upward so the lowest qualifying index wins.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        sel_found = 1'b0;
        sel_type  = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (!I_EMPTY[i] && coin_value(3'(i)) <= O_REMAIN) begin
                sel_found = 1'b1;
                sel_type  = 3'(i);
            end
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every register
    // updates from values sampled before the edge.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state       <= IDLE;
            timer       <= 8'd0;
            O_COIN_REQ  <= 1'b0;
            O_COIN_TYPE <= 3'd0;
            O_REMAIN    <= 16'd0;
            O_COUNT     <= 8'd0;
            O_BUSY      <= 1'b0;
            O_DONE      <= 1'b0;
            O_FAULT     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (I_START) begin
                        O_REMAIN <= I_AMOUNT;
                        O_COUNT  <= 8'd0;
                        O_BUSY   <= 1'b1;
                        if (I_AMOUNT == 16'd0) begin
                            O_DONE <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    if (O_REMAIN == 16'd0) begin
                        O_DONE <= 1'b1;
                        state  <= DONE;
                    end else if (sel_found) begin
                        O_COIN_TYPE <= sel_type;
                        O_COIN_REQ  <= 1'b1;
                        timer       <= 8'd0;
                        state       <= REQ;
                    end else begin
                        O_FAULT <= 1'b1;
                        state   <= FAULT;
                    end
                end
                REQ: begin
                    // An acknowledge in the last allowed cycle beats the timeout.
                    if (I_COIN_ACK) begin
                        O_REMAIN   <= O_REMAIN - coin_value(O_COIN_TYPE);
                        O_COUNT    <= (O_COUNT == 8'd255) ? O_COUNT : O_COUNT + 8'd1;
                        O_COIN_REQ <= 1'b0;
                        state      <= SELECT;
                    end else if (timer == 8'(TIMEOUT - 1)) begin
                        O_COIN_REQ <= 1'b0;
                        O_FAULT    <= 1'b1;
                        state      <= FAULT;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE: begin
                    O_DONE <= 1'b0;
                    O_BUSY <= 1'b0;
                    state  <= IDLE;
                end
                FAULT: begin
                    O_FAULT    <= 1'b1;
                    O_BUSY     <= 1'b1;
                    O_COIN_REQ <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser: stimulus driven and outputs
// sampled on the falling clock edge, expected values worked out by hand.
module tb_change_dispenser;

    logic        I_CLK = 1'b0;
    logic        I_RESET = 1'b0;
    logic        I_START = 1'b0;
    logic [15:0] I_AMOUNT = 16'd0;
    logic [5:0]  I_EMPTY = 6'd0;
    logic        I_COIN_ACK;
    logic        O_COIN_REQ;
    logic [2:0]  O_COIN_TYPE;
    logic [15:0] O_REMAIN;
    logic [7:0]  O_COUNT;
    logic        O_BUSY;
    logic        O_DONE;
    logic        O_FAULT;

    logic auto_ack = 1'b0;
    logic manual_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // Transaction observations gathered by run_txn
    logic [2:0] types[$];
    int         first_req;
    int         done_cycle;
    int         n_reqs;

    // Hopper model: either acknowledges in the same cycle as the request or is driven by hand.
    assign I_COIN_ACK = manual_ack | (auto_ack & O_COIN_REQ);

    always #5 I_CLK = ~I_CLK;

    change_dispenser #(.TIMEOUT(200)) dut (
        .I_CLK      (I_CLK),
        .I_RESET    (I_RESET),
        .I_START    (I_START),
        .I_AMOUNT   (I_AMOUNT),
        .I_EMPTY    (I_EMPTY),
        .I_COIN_ACK (I_COIN_ACK),
        .O_COIN_REQ (O_COIN_REQ),
        .O_COIN_TYPE(O_COIN_TYPE),
        .O_REMAIN   (O_REMAIN),
        .O_COUNT    (O_COUNT),
        .O_BUSY     (O_BUSY),
        .O_DONE     (O_DONE),
        .O_FAULT    (O_FAULT)
    );

    task automatic do_reset();
        I_RESET = 1'b1;
        @(negedge I_CLK);
        @(negedge I_CLK);
        I_RESET = 1'b0;
    endtask

    // Pulse start for one cycle, then log every requested coin until DONE/FAULT or budget.
    task automatic run_txn(input logic [15:0] amt, input logic [5:0] emp, input int budget);
        types.delete();
        first_req  = -1;
        done_cycle = -1;
        n_reqs     = 0;
        I_AMOUNT = amt;
        I_EMPTY  = emp;
        I_START  = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge I_CLK);
            I_START = 1'b0;
            if (O_COIN_REQ) begin
                types.push_back(O_COIN_TYPE);
                n_reqs++;
                if (first_req < 0) first_req = c;
            end
            if (O_DONE) begin
                done_cycle = c;
                break;
            end
            if (O_FAULT) break;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({O_COIN_REQ, O_COIN_TYPE, O_REMAIN, O_COUNT, O_BUSY, O_DONE, O_FAULT} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b type=%0d remain=%0d count=%0d busy=%b done=%b fault=%b, want all 0",
                     O_COIN_REQ, O_COIN_TYPE, O_REMAIN, O_COUNT, O_BUSY, O_DONE, O_FAULT);
        end
    endtask

    task automatic test_basic_135();
        do_reset();
        auto_ack = 1'b1;
        run_txn(16'd135, 6'd0, 50);
        auto_ack = 1'b0;
        checks++;
        if (types.size() != 3 || types[0] !== 3'd1 || types[1] !== 3'd2 || types[2] !== 3'd3) begin
            errors++;
            $display("FAIL basic_types: got %p, want '{1,2,3}", types);
        end
        checks++;
        if (first_req != 2) begin
            errors++;
            $display("FAIL basic_first_req_latency: got %0d, want 2", first_req);
        end
        checks++;
        if (done_cycle != 8) begin
            errors++;
            $display("FAIL basic_done_latency: got %0d, want 8", done_cycle);
        end
        checks++;
        if (O_COUNT !== 8'd3 || O_REMAIN !== 16'd0 || O_FAULT !== 1'b0 || O_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL basic_final: got count=%0d remain=%0d fault=%b busy=%b, want 3 0 0 1",
                     O_COUNT, O_REMAIN, O_FAULT, O_BUSY);
        end
        @(negedge I_CLK);
        checks++;
        if (O_DONE !== 1'b0 || O_BUSY !== 1'b0 || O_COUNT !== 8'd3 || O_REMAIN !== 16'd0) begin
            errors++;
            $display("FAIL basic_after_done: got done=%b busy=%b count=%0d remain=%0d, want 0 0 3 0",
                     O_DONE, O_BUSY, O_COUNT, O_REMAIN);
        end
    endtask

    task automatic test_zero_amount();
        do_reset();
        auto_ack = 1'b1;
        run_txn(16'd0, 6'd0, 10);
        auto_ack = 1'b0;
        checks++;
        if (done_cycle != 1 || n_reqs != 0 || O_COUNT !== 8'd0) begin
            errors++;
            $display("FAIL zero_amount: got done_cycle=%0d reqs=%0d count=%0d, want 1 0 0",
                     done_cycle, n_reqs, O_COUNT);
        end
    endtask

    task automatic test_quarters_empty();
        do_reset();
        auto_ack = 1'b1;
        run_txn(16'd30, 6'b000100, 50);
        auto_ack = 1'b0;
        checks++;
        if (types.size() != 3 || types[0] !== 3'd3 || types[1] !== 3'd3 || types[2] !== 3'd3
            || O_COUNT !== 8'd3 || done_cycle < 0) begin
            errors++;
            $display("FAIL quarters_empty: got types=%p count=%0d done_cycle=%0d, want '{3,3,3} 3 done",
                     types, O_COUNT, done_cycle);
        end
    endtask

    task automatic test_no_coin_fault();
        do_reset();
        auto_ack = 1'b1;
        run_txn(16'd3, 6'b100000, 20);
        auto_ack = 1'b0;
        checks++;
        if (O_FAULT !== 1'b1 || O_REMAIN !== 16'd3 || n_reqs != 0 || O_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL no_coin_fault: got fault=%b remain=%0d reqs=%0d busy=%b, want 1 3 0 1",
                     O_FAULT, O_REMAIN, n_reqs, O_BUSY);
        end
        I_AMOUNT = 16'd5;
        I_EMPTY  = 6'd0;
        I_START  = 1'b1;
        @(negedge I_CLK);
        I_START = 1'b0;
        repeat (3) @(negedge I_CLK);
        checks++;
        if (O_FAULT !== 1'b1 || O_REMAIN !== 16'd3 || O_COIN_REQ !== 1'b0 || O_DONE !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky: got fault=%b remain=%0d req=%b done=%b, want 1 3 0 0",
                     O_FAULT, O_REMAIN, O_COIN_REQ, O_DONE);
        end
    endtask

    task automatic test_timeout();
        int high_cnt;
        do_reset();
        high_cnt = 0;
        I_AMOUNT = 16'd100;
        I_EMPTY  = 6'd0;
        I_START  = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge I_CLK);
            I_START = 1'b0;
            if (O_COIN_REQ) high_cnt++;
            if (O_FAULT) break;
        end
        checks++;
        if (high_cnt != 200) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d, want 200", high_cnt);
        end
        checks++;
        if (O_FAULT !== 1'b1 || O_COIN_REQ !== 1'b0 || O_REMAIN !== 16'd100 || O_COUNT !== 8'd0) begin
            errors++;
            $display("FAIL timeout_final: got fault=%b req=%b remain=%0d count=%0d, want 1 0 100 0",
                     O_FAULT, O_COIN_REQ, O_REMAIN, O_COUNT);
        end
    endtask

    task automatic test_ack_last_cycle();
        int stable_bad;
        do_reset();
        stable_bad = 0;
        I_AMOUNT = 16'd1;
        I_EMPTY  = 6'd0;
        I_START  = 1'b1;
        @(negedge I_CLK);
        I_START = 1'b0;
        @(negedge I_CLK);
        // Request cycles 1..199 without acknowledge; hopper flags change mid-request.
        for (int k = 1; k < 200; k++) begin
            I_EMPTY = 6'b111111;
            if (O_COIN_REQ !== 1'b1 || O_COIN_TYPE !== 3'd5) stable_bad++;
            @(negedge I_CLK);
        end
        checks++;
        if (stable_bad != 0 || O_COIN_REQ !== 1'b1 || O_COIN_TYPE !== 3'd5) begin
            errors++;
            $display("FAIL req_stable: got unstable_cycles=%0d req=%b type=%0d, want 0 1 5",
                     stable_bad, O_COIN_REQ, O_COIN_TYPE);
        end
        manual_ack = 1'b1;
        @(negedge I_CLK);
        manual_ack = 1'b0;
        checks++;
        if (O_FAULT !== 1'b0 || O_COUNT !== 8'd1 || O_REMAIN !== 16'd0 || O_COIN_REQ !== 1'b0) begin
            errors++;
            $display("FAIL ack_last_cycle: got fault=%b count=%0d remain=%0d req=%b, want 0 1 0 0",
                     O_FAULT, O_COUNT, O_REMAIN, O_COIN_REQ);
        end
        @(negedge I_CLK);
        checks++;
        if (O_DONE !== 1'b1) begin
            errors++;
            $display("FAIL ack_last_cycle_done: got done=%b, want 1", O_DONE);
        end
        @(negedge I_CLK);
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        I_AMOUNT = 16'd100;
        I_EMPTY  = 6'd0;
        I_START  = 1'b1;
        @(negedge I_CLK);
        I_START = 1'b0;
        @(negedge I_CLK);
        checks++;
        if (O_COIN_REQ !== 1'b1 || O_COIN_TYPE !== 3'd1) begin
            errors++;
            $display("FAIL mid_req_setup: got req=%b type=%0d, want 1 1", O_COIN_REQ, O_COIN_TYPE);
        end
        I_RESET    = 1'b1;
        manual_ack = 1'b1;
        @(negedge I_CLK);
        I_RESET    = 1'b0;
        manual_ack = 1'b0;
        checks++;
        if ({O_COIN_REQ, O_COIN_TYPE, O_REMAIN, O_COUNT, O_BUSY, O_DONE, O_FAULT} !== 31'd0) begin
            errors++;
            $display("FAIL reset_with_ack: got req=%b type=%0d remain=%0d count=%0d busy=%b done=%b fault=%b, want all 0",
                     O_COIN_REQ, O_COIN_TYPE, O_REMAIN, O_COUNT, O_BUSY, O_DONE, O_FAULT);
        end
        auto_ack = 1'b1;
        run_txn(16'd5, 6'd0, 20);
        auto_ack = 1'b0;
        checks++;
        if (types.size() != 1 || types[0] !== 3'd4 || done_cycle != 4 || O_COUNT !== 8'd1 || O_REMAIN !== 16'd0) begin
            errors++;
            $display("FAIL after_reset_txn: got types=%p done_cycle=%0d count=%0d remain=%0d, want '{4} 4 1 0",
                     types, done_cycle, O_COUNT, O_REMAIN);
        end
    endtask

    task automatic test_count_saturation();
        do_reset();
        auto_ack = 1'b1;
        run_txn(16'd300, 6'b011111, 1000);
        auto_ack = 1'b0;
        checks++;
        if (n_reqs != 300 || O_COUNT !== 8'd255 || O_REMAIN !== 16'd0 || done_cycle != 602) begin
            errors++;
            $display("FAIL count_saturation: got reqs=%0d count=%0d remain=%0d done_cycle=%0d, want 300 255 0 602",
                     n_reqs, O_COUNT, O_REMAIN, done_cycle);
        end
    endtask

    initial begin
        test_reset();
        test_basic_135();
        test_zero_amount();
        test_quarters_empty();
        test_no_coin_fault();
        test_timeout();
        test_ack_last_cycle();
        test_reset_mid_req();
        test_count_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
